// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin is off, statically high, or follows one shared
// 8-bit PWM waveform whose duty is shadowed and only updated at period boundaries.
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int              PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("pwm_peripheral: CLK_DIV must be in 1..255");
    end

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       duty_s_q, duty_s_d;
    logic [15:0]      out_q, out_d;
    logic             period_start_q, period_start_d;

    logic             pre_wrap;
    logic             pwm_level;
    logic [15:0]      en_all;
    logic [15:0]      pm_all;

    // NOTE: every signal driven here gets a value before any condition, so no latch is inferred.
    always_comb begin
        pre_wrap       = (pre_q == PRE_LAST);
        pre_d          = pre_wrap ? '0 : pre_q + PRE_W'(1);
        cnt_d          = pre_wrap ? cnt_q + 8'd1 : cnt_q;

        // The shadow only moves on the last prescaler tick of count 255, so a
        // new duty never lands in the middle of a period.
        duty_s_d       = (pre_wrap && cnt_q == 8'hFF) ? pwm_duty_cycle : duty_s_q;

        // 0xFF is forced to full-on rather than 255/256.
        pwm_level      = (duty_s_q == 8'hFF) || (cnt_q < duty_s_q);

        en_all         = {en_reg_out_15_8, en_reg_out_7_0};
        pm_all         = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        out_d          = en_all & (~pm_all | {16{pwm_level}});

        period_start_d = (cnt_q == 8'd0) && (pre_q == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q          <= '0;
            cnt_q          <= 8'd0;
            duty_s_q       <= 8'd0;
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            cnt_q          <= cnt_d;
            duty_s_q       <= duty_s_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: a time-based behavioural model checked
// every cycle, plus per-period high-time counts against hand-computed values.
module tb_pwm_peripheral;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_all = 16'h0000;
    logic [15:0] pm_all = 16'h0000;
    logic [7:0]  duty = 8'h00;
    logic [15:0] out;
    logic        period_start;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_all[7:0]),
        .en_reg_out_15_8 (en_all[15:8]),
        .en_reg_pwm_7_0  (pm_all[7:0]),
        .en_reg_pwm_15_8 (pm_all[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Model: position within the period is elapsed clocks since reset release
    // modulo the period; a pin is high for the first duty*CLK_DIV clocks.
    int          m_s    = 0;
    logic [7:0]  m_duty = 8'h00;
    logic [15:0] m_out  = 16'h0000;
    logic        m_ps   = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int x;
        bit level;
        if (!rst_n) begin
            m_s    = 0;
            m_duty = 8'h00;
            m_out  = 16'h0000;
            m_ps   = 1'b0;
        end else begin
            x     = m_s % PERIOD;
            level = (m_duty == 8'hFF) || (x < int'(m_duty) * CLK_DIV);
            for (int i = 0; i < 16; i++)
                m_out[i] = en_all[i] && (!pm_all[i] || level);
            m_ps = (x == 0);
            if (x == PERIOD - 1)
                m_duty = duty;
            m_s++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_out", 32'(out), 32'(m_out));
            check("model_period_start", 32'(period_start), 32'(m_ps));
        end
    end

    typedef struct {
        int          at;
        logic [15:0] en;
        logic [15:0] pm;
        logic [7:0]  duty;
    } chg_t;

    chg_t chg_q[$];
    int   highs[16];

    // Starts at cycle 0 of a period (negedge after the period_start edge),
    // counts high cycles per pin over one period, applies queued input changes,
    // and ends on cycle 0 of the next period.
    task automatic run_period();
        for (int p = 0; p < 16; p++) highs[p] = 0;
        for (int i = 0; i < PERIOD; i++) begin
            for (int p = 0; p < 16; p++)
                if (out[p]) highs[p]++;
            foreach (chg_q[k]) begin
                if (chg_q[k].at == i) begin
                    en_all = chg_q[k].en;
                    pm_all = chg_q[k].pm;
                    duty   = chg_q[k].duty;
                end
            end
            @(negedge clk);
        end
        chg_q.delete();
        check("period_length", 32'(period_start), 32'd1);
    endtask

    initial begin
        en_all = 16'hFFFF;
        pm_all = 16'hFFFF;
        duty   = 8'h80;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_period_start", 32'(period_start), 32'd1);
        check("first_out_low", 32'(out), 32'h0000);

        // Into period 1 (duty 0x80), then reset mid-period while pins are high.
        repeat (PERIOD + 1000) @(negedge clk);
        check("pre_reset_high", 32'(out), 32'hFFFF);
        #3 rst_n = 1'b0;
        #1;
        check("reset_out", 32'(out), 32'h0000);
        check("reset_period_start", 32'(period_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_period_start", 32'(period_start), 32'd1);

        // Period 0: old duty discarded, shadow is 0.
        run_period();
        check("reset_period_high", 32'(highs[0]), 32'd0);

        // Period 1: duty 0x80, rising with period_start.
        check("rise_with_ps", 32'(out), 32'hFFFF);
        chg_q.push_back('{1000, 16'hFFFF, 16'hFFFF, 8'h00});
        run_period();
        check("duty80_high", 32'(highs[0]), 32'd1664);

        // Period 2: duty 0x00.
        chg_q.push_back('{1000, 16'hFFFF, 16'hFFFF, 8'hFF});
        run_period();
        check("duty00_high", 32'(highs[0]), 32'd0);

        // Period 3: duty 0xFF; mode mix applied mid-period.
        chg_q.push_back('{1000, 16'h00FF, 16'h0F0F, 8'h40});
        run_period();
        check("dutyFF_high", 32'(highs[0]), 32'd3328);
        check("en_clear_mid_period", 32'(highs[8]), 32'd1001);

        // Period 4: duty 0x40, change to 0xC0 at cnt 0x20 must not disturb it.
        chg_q.push_back('{416, 16'h00FF, 16'h0F0F, 8'hC0});
        run_period();
        check("mix_pwm_high", 32'(highs[0]), 32'd832);
        check("mix_static_high", 32'(highs[4]), 32'd3328);
        check("mix_off_high", 32'(highs[8]), 32'd0);

        // Period 5: shadowed 0xC0; pin 5 switched to PWM on the last cycle.
        chg_q.push_back('{PERIOD - 1, 16'h00FF, 16'h0F2F, 8'hC0});
        run_period();
        check("dutyC0_high", 32'(highs[0]), 32'd2496);
        check("static_pin5_high", 32'(highs[5]), 32'd3328);
        check("off_pin12_high", 32'(highs[12]), 32'd0);

        // Period 6: immediate enable clear, enable-vs-mode priority, boundary capture.
        chg_q.push_back('{100, 16'h009F, 16'h0F6F, 8'hC0});
        chg_q.push_back('{PERIOD - 2, 16'h009F, 16'h0F6F, 8'h10});
        chg_q.push_back('{PERIOD - 1, 16'h009F, 16'h0F6F, 8'h20});
        run_period();
        check("en_clear_pin5", 32'(highs[5]), 32'd101);
        check("en_dominates_pin6", 32'(highs[6]), 32'd101);
        check("dutyC0_again", 32'(highs[0]), 32'd2496);

        // Period 7: value present on the boundary edge was captured.
        run_period();
        check("boundary_capture", 32'(highs[0]), 32'd208);

        // Period 8: value one clock late waited a full period.
        run_period();
        check("late_write_deferred", 32'(highs[0]), 32'd416);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Drives 16 output pins from the five 8-bit control registers produced by the SPI register block. Each pin is either off, statically high, or driven by one shared 8-bit PWM waveform. The block sits directly downstream of the SPI peripheral. It runs on the fast system clock and keeps the PWM counter and the duty shadow register.

## Interface
Parameters:
- `CLK_DIV`, default 13: system clocks per PWM counter step. Legal range 1..255. At 10 MHz the default gives about 3.0 kHz PWM.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `en_reg_out_7_0`, input, 8: output enable, pins 7:0 (SPI register 0x00).
- `en_reg_out_15_8`, input, 8: output enable, pins 15:8 (register 0x01).
- `en_reg_pwm_7_0`, input, 8: PWM mode select, pins 7:0 (register 0x02).
- `en_reg_pwm_15_8`, input, 8: PWM mode select, pins 15:8 (register 0x03).
- `pwm_duty_cycle`, input, 8: shared duty cycle (register 0x04).
- `out`, output, 16: registered pin drive.
- `period_start`, output, 1: one-clock pulse marking the first output cycle of each PWM period.

## Operation
- Inputs are treated as quasi-static, clk-domain register values. No handshake and no synchronisation happen in this block.
- Prescaler `pre` counts 0..CLK_DIV-1 and wraps to 0.
  - When CLK_DIV=1, `pre` stays 0.
  - Its width is max(1, clog2(CLK_DIV)).
- 8-bit counter `cnt` increments when `pre==CLK_DIV-1`, wrapping 255->0. Neither counter ever stops.
- Duty shadow `duty_s`:
  - loads `pwm_duty_cycle` on the clock edge where `cnt==255 && pre==CLK_DIV-1`;
  - otherwise holds.
  - This makes duty changes glitch-free and applied only at period boundaries.
- PWM level: `pwm = (duty_s==8'hFF) | (cnt < duty_s)`.
  - duty 0x00 gives constant low.
  - duty 0xFF gives constant high, not 255/256.
- Per pin i, with `en = {en_reg_out_15_8, en_reg_out_7_0}` and `pm = {en_reg_pwm_15_8, en_reg_pwm_7_0}`:
  - `en[i]==0` -> `out[i]` = 0, regardless of `pm[i]`;
  - `en[i]==1 && pm[i]==0` -> `out[i]` = 1;
  - `en[i]==1 && pm[i]==1` -> `out[i]` = `pwm`.
- Enable and mode changes are not shadowed. They take effect on the next clock edge, including mid-period.
- `period_start` is registered. It is 1 in the cycle after the edge where the state was `cnt==0 && pre==0`, otherwise 0.

## Timing
- Reset values (asserted asynchronously, immediate): `pre`=0, `cnt`=0, `duty_s`=0x00, `out`=16'h0000, `period_start`=0.
- Edge 1 after reset release:
  - `out` reflects state (0,0);
  - `period_start` goes to 1 for one clock.
- The first period after reset uses `duty_s`=0, so PWM pins are low for 256*CLK_DIV clocks. The first shadow load happens at the end of that period.
- Period is exactly 256*CLK_DIV clocks.
  - High time is duty*CLK_DIV clocks for duty 1..254.
  - duty 0x00 gives 0 clocks high; duty 0xFF gives the full period high.
- Latency: one clock from any input or state change to `out`.
  - A PWM pin rises in the same cycle as `period_start`=1, for duty ≥1.
- Duty write at the boundary edge itself:
  - the value present on that edge is captured;
  - a value arriving one clock later waits a full period.
- Reset mid-period: all state clears immediately. Counting restarts from (0,0) after release, and the previous duty is discarded.
- Simultaneous enable-clear and mode-set on a pin: `out[i]`=0 on the next edge, because enable dominates.

## Test plan
- Reset check:
  - stimulus: assert `rst_n`=0 mid-period with all pins enabled in PWM mode and duty 0x80;
  - response: `out`=0x0000 and `period_start`=0 immediately;
  - response: after release, `period_start` pulses on edge 1, then every 3328 clocks.
- Basic PWM with CLK_DIV=13:
  - stimulus: `en`=0xFFFF, `pm`=0xFFFF, duty 0x80;
  - response: from the second period on, every pin is high 1664 clocks and low 1664 clocks per 3328-clock period;
  - response: rising edges are coincident with `period_start`.
- Duty extremes:
  - stimulus: duty 0x00;
  - response: PWM pins stay constant 0 for a full period;
  - stimulus: duty 0xFF;
  - response: PWM pins stay constant 1 for a full period, no low cycle.
- Mode mixing:
  - stimulus: `en`=0x00FF, `pm`=0x0F0F, duty 0x40;
  - response: `out[3:0]` PWM at 832/3328 high; `out[7:4]`=1 static; `out[15:8]`=0.
- Glitch-free duty update:
  - stimulus: change duty 0x40->0xC0 at `cnt`=0x20 mid-period;
  - response: the current period still ends high time at 832 clocks;
  - response: the next period is high for 2496 clocks.
- Immediate enable:
  - stimulus: clear `en[5]` while `out[5]` is high in PWM mode;
  - response: `out[5]`=0 exactly one clock later, with no wait for the period boundary.
